// File: rtl/hex_display_scanner_if.sv
// Bus between the result registers and the 7-segment scanner.
// Master loads the shadow values; slave drives the decoder and anode pins.
interface hex_display_scanner_if;
   logic [15:0] data;
   logic        load;
   logic [3:0]  dp_in;
   logic [3:0]  en;
   logic        blank_lz;
   logic [3:0]  digit;
   logic [3:0]  anode;
   logic        dp;

   modport master (
      output data, load, dp_in, en, blank_lz,
      input  digit, anode, dp
   );

   modport slave (
      input  data, load, dp_in, en, blank_lz,
      output digit, anode, dp
   );
endinterface

// File: rtl/hex_display_scanner.sv
// 4-digit common-anode display scanner: shadowed value, prescaled
// position rotation, anti-ghost guard and leading-zero blanking.
module hex_display_scanner #(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 1000
) (
   input logic             clk,
   input logic             reset,
   hex_display_scanner_if.slave bus
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

   logic [15:0]   shadow_data_q;
   logic [3:0]    shadow_dp_q;
   logic [3:0]    shadow_en_q;
   logic          shadow_lz_q;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [1:0]    sel_q;
   logic [1:0]    sel_d;
   logic          tick;

   logic [3:0]    digit_q;
   logic [3:0]    digit_d;
   logic [3:0]    anode_q;
   logic [3:0]    anode_d;
   logic          dp_q;
   logic          dp_d;

   logic [3:0]    nib_zero;
   logic [3:0]    lz_run;
   logic [3:0]    blank;
   logic          guard;
   logic          off;

   if (GUARD > 0) begin : g_guard
      assign guard = (cnt_q < GUARD_C);
   end else begin : g_noguard
      assign guard = 1'b0;
   end

   always_comb begin
      tick  = (cnt_q == CNT_MAX);
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      sel_d = tick ? sel_q + 2'd1 : sel_q;
   end

   // lz_run[s]: nibbles s..3 all zero; position 0 is never suppressed
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         nib_zero[i] = (shadow_data_q[4*i +: 4] == 4'h0);
      end
      lz_run[3] = nib_zero[3];
      lz_run[2] = nib_zero[2] & lz_run[3];
      lz_run[1] = nib_zero[1] & lz_run[2];
      lz_run[0] = 1'b0;
      blank     = ~shadow_en_q | ({4{shadow_lz_q}} & lz_run);
   end

   always_comb begin
      off     = guard | blank[sel_q];
      digit_d = shadow_data_q[{sel_q, 2'b00} +: 4];
      anode_d = off ? 4'hF : ~(4'b0001 << sel_q);
      dp_d    = shadow_dp_q[sel_q] & ~off;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_data_q <= '0;
         shadow_dp_q   <= '0;
         shadow_en_q   <= '0;
         shadow_lz_q   <= 1'b0;
      end else if (bus.load) begin
         shadow_data_q <= bus.data;
         shadow_dp_q   <= bus.dp_in;
         shadow_en_q   <= bus.en;
         shadow_lz_q   <= bus.blank_lz;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         sel_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
         sel_q <= sel_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_q <= 4'h0;
         anode_q <= 4'hF;
         dp_q    <= 1'b0;
      end else begin
         digit_q <= digit_d;
         anode_q <= anode_d;
         dp_q    <= dp_d;
      end
   end

   assign bus.digit = digit_q;
   assign bus.anode = anode_q;
   assign bus.dp    = dp_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner with REFRESH_DIV=4, GUARD=1.
// Expected outputs are queued per cycle number and checked on negedges.
module tb_hex_display_scanner;

   localparam int RD = 4;
   localparam int GD = 1;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [3:0] dig;
      logic       dp;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   base = 0;
   exp_t q[$];
   exp_t e;

   hex_display_scanner_if bus();

   hex_display_scanner #(
      .REFRESH_DIV(RD),
      .GUARD      (GD)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every entry due at or before this cycle is compared now
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL stale: entry for cycle %0d seen at cycle %0d",
                     e.cyc, cyc);
         end else if (bus.anode !== e.an || bus.digit !== e.dig ||
                      bus.dp !== e.dp) begin
            errors++;
            $display("FAIL out cyc=%0d: got an=%b dig=%h dp=%b, exp an=%b dig=%h dp=%b",
                     cyc, bus.anode, bus.digit, bus.dp, e.an, e.dig, e.dp);
         end
      end
   end

   function automatic int st(input int m);
      return base + RD * m;
   endfunction

   task automatic push(input int c, input logic [3:0] an,
                       input logic [3:0] dig, input logic dpv);
      exp_t x;
      x.cyc = c;
      x.an  = an;
      x.dig = dig;
      x.dp  = dpv;
      q.push_back(x);
   endtask

   // One slot: guard cycle with anodes off, then three driven cycles
   task automatic push_slot(input int c, input logic [3:0] dig,
                            input logic [3:0] an, input logic dpv);
      push(c, 4'hF, dig, 1'b0);
      for (int i = 1; i < RD; i++) push(c + i, an, dig, dpv);
   endtask

   // Four consecutive slots; nibble i of digs/ans belongs to slot m0+i
   task automatic push4(input int m0, input logic [15:0] digs,
                        input logic [15:0] ans, input logic [3:0] dps);
      for (int i = 0; i < 4; i++)
         push_slot(st(m0 + i), digs[4*i +: 4], ans[4*i +: 4], dps[i]);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Load sampled on the tick edge just before slot m starts
   task automatic load_at(input int m, input logic [15:0] d,
                          input logic [3:0] env, input logic [3:0] dpi,
                          input logic lz);
      wait_cyc(st(m) - 2);
      bus.data     = d;
      bus.en       = env;
      bus.dp_in    = dpi;
      bus.blank_lz = lz;
      bus.load     = 1'b1;
      @(posedge clk);
      #1;
      bus.load = 1'b0;
   endtask

   initial begin
      int t;
      reset        = 1'b1;
      bus.load     = 1'b0;
      bus.data     = 16'h0;
      bus.dp_in    = 4'h0;
      bus.en       = 4'h0;
      bus.blank_lz = 1'b0;

      for (int c = 1; c <= 3; c++) push(c, 4'hF, 4'h0, 1'b0);
      wait_cyc(3);
      reset = 1'b0;
      base  = 4;

      // idle after reset: en=0, everything blank
      push4(0, 16'h0000, 16'hFFFF, 4'h0);

      push4(4, 16'h0000, 16'h7BDE, 4'h0);
      load_at(4, 16'h0000, 4'hF, 4'h0, 1'b0);

      push4(8, 16'h1A3F, 16'h7BDE, 4'h0);
      load_at(8, 16'h1A3F, 4'hF, 4'h0, 1'b0);

      push4(12, 16'h0040, 16'hFFDE, 4'h0);
      load_at(12, 16'h0040, 4'hF, 4'h0, 1'b1);

      push4(16, 16'h0000, 16'hFFFE, 4'h0);
      load_at(16, 16'h0000, 4'hF, 4'h0, 1'b1);

      push4(20, 16'h1A3F, 16'h7BDE, 4'b0100);
      load_at(20, 16'h1A3F, 4'hF, 4'b0100, 1'b0);

      push4(24, 16'h1A3F, 16'h7FDE, 4'h0);
      load_at(24, 16'h1A3F, 4'b1011, 4'b0100, 1'b0);

      push4(28, 16'h5634, 16'h7BDE, 4'h0);
      load_at(28, 16'h1234, 4'hF, 4'h0, 1'b0);
      load_at(30, 16'h5678, 4'hF, 4'h0, 1'b0);
      bus.data     = 16'hFFFF;
      bus.en       = 4'h0;
      bus.dp_in    = 4'hF;
      bus.blank_lz = 1'b1;

      // reset asserted mid-slot while position 1 is lit
      push_slot(st(32), 4'hF, 4'hE, 1'b0);
      push(136, 4'hF, 4'h3, 1'b0);
      push(137, 4'hF, 4'h0, 1'b0);
      push(138, 4'hF, 4'h0, 1'b0);
      push(139, 4'hF, 4'h0, 1'b0);
      for (int c = 140; c <= 142; c++) push(c, 4'hE, 4'hF, 1'b0);
      push_slot(143, 4'h3, 4'hD, 1'b0);
      load_at(32, 16'h1A3F, 4'hF, 4'h0, 1'b0);
      wait_cyc(137);
      reset = 1'b1;
      wait_cyc(138);
      reset        = 1'b0;
      bus.data     = 16'h1A3F;
      bus.en       = 4'hF;
      bus.dp_in    = 4'h0;
      bus.blank_lz = 1'b0;
      bus.load     = 1'b1;
      @(posedge clk);
      #1;
      bus.load = 1'b0;

      t = 0;
      while (q.size() > 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
